// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
//  Bundles the two requester ports (A: 65xx bus side, B: DMA/video fetcher)
//  and the SRAM-controller side of the arbiter into one interface.
//  Ports (signals):
//   a_req/b_req, a_we/b_we, a_addr/b_addr, a_wdata/b_wdata : requester -> arbiter
//   a_rdata/b_rdata, a_ack/b_ack                           : arbiter -> requester
//   mem_address, mem_data_write, mem_read, mem_write       : arbiter -> sram ctrl
//   mem_data_read, mem_ready                               : sram ctrl -> arbiter
//  Modports: slave  = arbiter view
//            master = requester / controller-model view (testbench)
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_ack;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_ack;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_data_read;
    logic          mem_ready;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ack,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack,
        output mem_address, mem_data_write, mem_read, mem_write,
        input  mem_data_read, mem_ready
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ack,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack,
        input  mem_address, mem_data_write, mem_read, mem_write,
        output mem_data_read, mem_ready
    );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//  Shares one external SRAM controller between port A and port B. Accesses
//  are serialised through IDLE -> ISSUE -> WAIT -> IDLE; each transaction
//  produces exactly one mem_read/mem_write strobe and one ack pulse to the
//  winner. Fixed priority (FAIR=0, A wins) or round-robin (FAIR=1, the port
//  granted last loses a tie). A watchdog force-completes a transaction when
//  mem_ready does not arrive within TIMEOUT WAIT cycles.
//  Ports:
//   clk          system clock, posedge
//   reset_n      synchronous reset, active low
//   bus          sram_arbiter_if.slave (requester ports + sram controller side)
//   timeout_err  sticky watchdog-expiry flag, cleared only by reset
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int FAIR    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    sram_arbiter_if.slave bus,
    output logic          timeout_err
);
    // Watchdog only has to reach TIMEOUT-1.
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic           win_q, win_d;
    logic           we_q, we_d;
    logic           last_grant_q, last_grant_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           a_ack_q, a_ack_d;
    logic           b_ack_q, b_ack_d;
    logic [DW-1:0]  a_rdata_q, a_rdata_d;
    logic [DW-1:0]  b_rdata_q, b_rdata_d;
    logic           terr_q, terr_d;

    logic           a_elig, b_elig, pick_b;
    logic           done;
    logic [DW-1:0]  done_data;

    // A port whose ack is high this cycle still shows req (it drops it only
    // after seeing the ack), so it is masked to avoid serving it twice.
    always_comb begin
        a_elig = bus.a_req & ~a_ack_q;
        b_elig = bus.b_req & ~b_ack_q;
        if ((FAIR != 0) && a_elig && b_elig)
            pick_b = (last_grant_q == PORT_A);
        else
            pick_b = ~a_elig;
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wdog_d       = wdog_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        terr_d       = terr_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        done         = 1'b0;
        done_data    = bus.mem_data_read;

        unique case (state_q)
            S_IDLE: begin
                if (a_elig || b_elig) begin
                    win_d        = pick_b;
                    last_grant_d = pick_b;
                    we_d         = pick_b ? bus.b_we    : bus.a_we;
                    addr_d       = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d      = pick_b ? bus.b_wdata : bus.a_wdata;
                    // Strobe flop is loaded here so it is high exactly during ISSUE.
                    mem_read_d   = ~we_d;
                    mem_write_d  = we_d;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Ready takes precedence over expiry in the last watchdog cycle.
                if (bus.mem_ready) begin
                    done = 1'b1;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    done_data = '1;
                    terr_d    = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            state_d = S_IDLE;
            if (win_q == PORT_B) b_ack_d = 1'b1;
            else                 a_ack_d = 1'b1;
            // Writes leave the winner's read data untouched.
            if (!we_q) begin
                if (win_q == PORT_B) b_rdata_d = done_data;
                else                 a_rdata_d = done_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            win_q        <= PORT_A;
            we_q         <= 1'b0;
            last_grant_q <= PORT_B;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wdog_q       <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            wdog_q       <= wdog_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            terr_q       <= terr_d;
        end
    end

    assign bus.a_ack          = a_ack_q;
    assign bus.b_ack          = b_ack_q;
    assign bus.a_rdata        = a_rdata_q;
    assign bus.b_rdata        = b_rdata_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_data_write = wdata_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign timeout_err        = terr_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Two arbiters side by side: instance 0 fixed priority, instance 1 round-robin,
// both with an 8-cycle watchdog.
module tb_sram_arbiter;
    localparam int AW = 18, DW = 16, T = 8, NCYC = 2500;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req [2][2], we [2][2];
    logic [AW-1:0] addr[2][2];
    logic [DW-1:0] wd  [2][2];
    logic          rdy [2];
    logic [DW-1:0] mrd [2];
    logic          ack [2][2];
    logic [DW-1:0] rd  [2][2];
    logic          mr[2], mw[2], terr[2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mwd[2];

    sram_arbiter_if #(.AW(AW), .DW(DW)) bif[2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bif[g].a_req         = req[g][0];
        assign bif[g].a_we          = we[g][0];
        assign bif[g].a_addr        = addr[g][0];
        assign bif[g].a_wdata       = wd[g][0];
        assign bif[g].b_req         = req[g][1];
        assign bif[g].b_we          = we[g][1];
        assign bif[g].b_addr        = addr[g][1];
        assign bif[g].b_wdata       = wd[g][1];
        assign bif[g].mem_ready     = rdy[g];
        assign bif[g].mem_data_read = mrd[g];
        assign ack[g][0] = bif[g].a_ack;
        assign ack[g][1] = bif[g].b_ack;
        assign rd[g][0]  = bif[g].a_rdata;
        assign rd[g][1]  = bif[g].b_rdata;
        assign mr[g]     = bif[g].mem_read;
        assign mw[g]     = bif[g].mem_write;
        assign maddr[g]  = bif[g].mem_address;
        assign mwd[g]    = bif[g].mem_data_write;

        sram_arbiter #(.AW(AW), .DW(DW), .FAIR(g), .TIMEOUT(T)) dut (
            .clk(clk), .reset_n(rst_n), .bus(bif[g]), .timeout_err(terr[g]));
    end

    int vecs = 0, errs = 0;
    int nstb[2], stbc[2];
    int acklog[2][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            rdy[d] = 1'b0; mrd[d] = '0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wd[d][p] = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            stbc[d] = -10; nstb[d] = 0; acklog[d].delete();
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s d%0d a_ack", tag, d), ack[d][0], 0);
        chk($sformatf("%s d%0d b_ack", tag, d), ack[d][1], 0);
        chk($sformatf("%s d%0d a_rdata", tag, d), rd[d][0], 0);
        chk($sformatf("%s d%0d b_rdata", tag, d), rd[d][1], 0);
        chk($sformatf("%s d%0d mem_read", tag, d), mr[d], 0);
        chk($sformatf("%s d%0d mem_write", tag, d), mw[d], 0);
        chk($sformatf("%s d%0d mem_address", tag, d), maddr[d], 0);
        chk($sformatf("%s d%0d mem_data_write", tag, d), mwd[d], 0);
        chk($sformatf("%s d%0d timeout_err", tag, d), terr[d], 0);
    endtask

    // Zero-wait memory on both instances; logs which port is acked. An acked
    // port drops req unless keep is set; once lim acks are logged all reqs drop.
    task automatic serve(input int ncyc, input bit keep, input int lim);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (mr[d] || mw[d]) begin nstb[d]++; stbc[d] = c; end
                if (ack[d][0] && ack[d][1]) chk($sformatf("d%0d dual ack", d), 1, 0);
                for (int p = 0; p < 2; p++)
                    if (ack[d][p]) begin
                        acklog[d].push_back(p);
                        if (!keep) req[d][p] = 1'b0;
                    end
                if (acklog[d].size() >= lim) begin req[d][0] = 1'b0; req[d][1] = 1'b0; end
                rdy[d] = (c == stbc[d] + 1);
                mrd[d] = DW'($urandom);
            end
        end
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            k;        // WAIT cycles before ready (>= T: never)
        logic [DW-1:0] mdata;
        int            lat;      // cycles from req-sampling edge to ack cycle
        logic [DW-1:0] exp_rd;   // requester's rdata after the ack
        logic          exp_terr;
    } vec_t;

    vec_t tv[7];
    logic [DW-1:0] shadow[2];

    // reference model state for the randomized run
    logic          m_busy[2], m_win[2], m_we[2], m_to[2], m_lg[2], m_terr[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wd[2], m_rd[2];
    int            m_stb[2], m_ack[2], m_rdy[2];
    logic [DW-1:0] m_rdat[2][2];
    logic          pend[2][2];
    int            acked_at[2][2];

    initial begin
        #1_000_000;
        $display("FAIL global time limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        tv[0] = '{0, 1'b0, 18'h00123, 16'h0000, 1,   16'h00A5, 4,  16'h00A5, 1'b0};
        tv[1] = '{1, 1'b1, 18'h3FFFF, 16'hBEEF, 0,   16'h1234, 3,  16'h0000, 1'b0};
        tv[2] = '{1, 1'b0, 18'h00000, 16'h0000, 7,   16'h5A5A, 10, 16'h5A5A, 1'b0};
        tv[3] = '{0, 1'b1, 18'h15555, 16'h0F0F, 3,   16'h0000, 6,  16'h00A5, 1'b0};
        tv[4] = '{0, 1'b0, 18'h2AAAA, 16'h0000, 100, 16'h0000, 10, 16'hFFFF, 1'b1};
        tv[5] = '{1, 1'b1, 18'h00777, 16'hCAFE, 100, 16'h0000, 10, 16'h5A5A, 1'b1};
        tv[6] = '{0, 1'b0, 18'h1ABCD, 16'h0000, 2,   16'h7E81, 5,  16'h7E81, 1'b1};

        rst_n = 1'b0;
        clear_inputs();
        tick();
        do_reset();
        chk_zero(0, "reset"); chk_zero(1, "reset");

        // ---- table-driven single transactions on instance 0 ----
        shadow[0] = '0; shadow[1] = '0;
        for (int i = 0; i < 7; i++) begin
            int p, o, sc, ac, ns;
            logic oack;
            p = tv[i].port; o = 1 - p;
            req[0][p] = 1'b1; we[0][p] = tv[i].we; addr[0][p] = tv[i].addr; wd[0][p] = tv[i].wdata;
            sc = -100; ac = -1; ns = 0; oack = 1'b0;
            for (int c = 1; c <= 40 && ac < 0; c++) begin
                tick();
                if (mr[0] || mw[0]) begin
                    ns++; sc = c;
                    chk($sformatf("v%0d strobe is write", i), mw[0], tv[i].we);
                    chk($sformatf("v%0d mem_address", i), maddr[0], tv[i].addr);
                    if (tv[i].we) chk($sformatf("v%0d mem_data_write", i), mwd[0], tv[i].wdata);
                end
                if (ack[0][o]) oack = 1'b1;
                if (ack[0][p]) begin ac = c; req[0][p] = 1'b0; end
                rdy[0] = (c == sc + 1 + tv[i].k);
                mrd[0] = rdy[0] ? tv[i].mdata : DW'($urandom);
            end
            rdy[0] = 1'b1; mrd[0] = 16'h3C3C;   // stray ready in the idle ack cycle
            chk($sformatf("v%0d ack latency", i), ac, tv[i].lat);
            chk($sformatf("v%0d strobe count", i), ns, 1);
            chk($sformatf("v%0d other ack", i), oack, 0);
            chk($sformatf("v%0d own rdata", i), rd[0][p], tv[i].exp_rd);
            chk($sformatf("v%0d other rdata", i), rd[0][o], shadow[o]);
            chk($sformatf("v%0d timeout_err", i), terr[0], tv[i].exp_terr);
            shadow[p] = tv[i].exp_rd;
            for (int c = 0; c < 3; c++) begin
                tick();
                rdy[0] = 1'b0;
                chk($sformatf("v%0d post ack", i), ack[0][0] | ack[0][1], 0);
                chk($sformatf("v%0d post strobe", i), mr[0] | mw[0], 0);
            end
        end

        // ---- reset during WAIT aborts the transaction ----
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 18'h01234;
        tick(); tick();                        // ISSUE, then WAIT
        rst_n = 1'b0; req[0][0] = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_zero(0, "midreset");
        rdy[0] = 1'b1; mrd[0] = 16'h1111;
        for (int c = 0; c < 4; c++) begin
            tick();
            rdy[0] = 1'b0;
            chk("midreset late ready ack", ack[0][0] | ack[0][1], 0);
            chk("midreset a_rdata", rd[0][0], 0);
        end

        // ---- simultaneous requests, then tie with last grant = A ----
        do_reset();
        for (int d = 0; d < 2; d++) begin
            addr[d][0] = 18'h00100; we[d][0] = 1'b0;
            addr[d][1] = 18'h00200; we[d][1] = 1'b1; wd[d][1] = 16'h5555;
            req[d][0] = 1'b1; req[d][1] = 1'b1;
        end
        serve(12, 1'b0, 99);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d both: acks", d), acklog[d].size(), 2);
            chk($sformatf("d%0d both: strobes", d), nstb[d], 2);
            if (acklog[d].size() == 2) begin
                chk($sformatf("d%0d both: first", d), acklog[d][0], 0);
                chk($sformatf("d%0d both: second", d), acklog[d][1], 1);
            end
            acklog[d].delete();
            req[d][0] = 1'b1;
        end
        serve(8, 1'b0, 99);
        for (int d = 0; d < 2; d++) begin
            acklog[d].delete();
            req[d][0] = 1'b1; req[d][1] = 1'b1;
        end
        serve(12, 1'b0, 99);
        for (int d = 0; d < 2; d++)
            if (acklog[d].size() == 2) begin
                chk($sformatf("d%0d tie winner", d), acklog[d][0], d);
                chk($sformatf("d%0d tie loser", d), acklog[d][1], 1 - d);
            end else chk($sformatf("d%0d tie acks", d), acklog[d].size(), 2);

        // ---- both held requesting for 8 transactions ----
        do_reset();
        for (int d = 0; d < 2; d++) begin
            we[d][0] = 1'b0; we[d][1] = 1'b1;
            req[d][0] = 1'b1; req[d][1] = 1'b1;
        end
        serve(40, 1'b1, 8);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d held: strobes", d), nstb[d], 8);
            chk($sformatf("d%0d held: acks", d), acklog[d].size(), 8);
            for (int i = 0; i < acklog[d].size(); i++)
                chk($sformatf("d%0d held: grant %0d", d, i), acklog[d][i], i % 2);
        end

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_lg[d] = 1'b1; m_terr[d] = 1'b0; m_win[d] = 1'b0; m_we[d] = 1'b0;
            m_to[d] = 1'b0; m_stb[d] = -1; m_ack[d] = -1; m_rdy[d] = -1;
            m_addr[d] = '0; m_wd[d] = '0; m_rd[d] = '0;
            for (int p = 0; p < 2; p++) begin
                m_rdat[d][p] = '0; pend[d][p] = 1'b0; acked_at[d][p] = -5;
            end
        end
        for (int n = 0; n < NCYC; n++) begin
            for (int d = 0; d < 2; d++) begin
                logic ackn[2];
                logic stb, ea, eb, w;
                int   k;
                ackn = '{1'b0, 1'b0};
                if (m_busy[d] && m_ack[d] == n) begin
                    m_busy[d] = 1'b0;
                    ackn[m_win[d]] = 1'b1;
                    acked_at[d][m_win[d]] = n;
                    if (!m_we[d]) m_rdat[d][m_win[d]] = m_to[d] ? '1 : m_rd[d];
                    if (m_to[d]) m_terr[d] = 1'b1;
                end
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("rnd n%0d d%0d ack%0d", n, d, p), ack[d][p], ackn[p]);
                    chk($sformatf("rnd n%0d d%0d rdata%0d", n, d, p), rd[d][p], m_rdat[d][p]);
                end
                stb = m_busy[d] && (m_stb[d] == n);
                chk($sformatf("rnd n%0d d%0d mem_read", n, d), mr[d], stb && !m_we[d]);
                chk($sformatf("rnd n%0d d%0d mem_write", n, d), mw[d], stb && m_we[d]);
                if (stb) chk($sformatf("rnd n%0d d%0d mem_address", n, d), maddr[d], m_addr[d]);
                if (stb && m_we[d]) chk($sformatf("rnd n%0d d%0d mem_data_write", n, d), mwd[d], m_wd[d]);
                chk($sformatf("rnd n%0d d%0d timeout_err", n, d), terr[d], m_terr[d]);

                for (int p = 0; p < 2; p++) begin
                    if (pend[d][p] && acked_at[d][p] == n - 1) pend[d][p] = 1'b0;
                    if (!pend[d][p] && $urandom_range(0, 3) == 0) begin
                        pend[d][p] = 1'b1;
                        we[d][p]   = 1'($urandom);
                        addr[d][p] = AW'($urandom);
                        wd[d][p]   = DW'($urandom);
                    end
                    req[d][p] = pend[d][p];
                end

                // memory side: real ready, late ready after expiry, or stray
                // ready while the arbiter is not waiting
                if (m_rdy[d] == n) begin
                    rdy[d] = 1'b1; mrd[d] = m_rd[d];
                end else begin
                    rdy[d] = (!m_busy[d] || m_stb[d] == n) && ($urandom_range(0, 5) == 0);
                    mrd[d] = DW'($urandom);
                end

                if (!m_busy[d]) begin
                    ea = pend[d][0] && !ackn[0];
                    eb = pend[d][1] && !ackn[1];
                    if (ea || eb) begin
                        w = (d == 1 && ea && eb) ? !m_lg[d] : !ea;
                        m_busy[d] = 1'b1; m_win[d] = w; m_lg[d] = w;
                        m_we[d] = we[d][w]; m_addr[d] = addr[d][w]; m_wd[d] = wd[d][w];
                        m_stb[d] = n + 1;
                        k = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 3)
                                                         : $urandom_range(0, T - 1);
                        m_to[d]  = (k >= T);
                        m_ack[d] = n + 3 + (m_to[d] ? T - 1 : k);
                        m_rdy[d] = m_to[d] ? m_ack[d] : n + 2 + k;
                        m_rd[d]  = DW'($urandom);
                    end
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
